// File: rtl/ir_pkg.sv
// Shared types and timing constants for the NEC infrared frame controller.
// Optional build macro used elsewhere: IR_EXT_ADDR_EN (extended 16-bit NEC address).
package ir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_LO,
      LEAD_HI,
      BIT_LO,
      BIT_HI,
      STOP,
      REP_LO,
      CHECK
   } ir_state_e;

   // Width counter rate: one tick every 10 us
   localparam int TICK_HZ = 100_000;

   localparam int T_LEAD_LO = 900;
   localparam int T_LEAD_HI = 450;
   localparam int T_REP_HI  = 225;
   localparam int T_BIT_LO  = 56;
   localparam int T_ZERO_HI = 56;
   localparam int T_ONE_HI  = 169;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  cmd;
      logic        rpt;
   } ir_frame_t;

   function automatic int tol_bound(input int nom, input int tol_pct, input bit upper);
      return upper ? (nom * (100 + tol_pct)) / 100 : (nom * (100 - tol_pct)) / 100;
   endfunction

endpackage

// File: rtl/ir_nec_ctrl_if.sv
// Result channel of the NEC controller: decoded address/command with valid/ready.
interface ir_nec_ctrl_if;
   logic        code_valid;
   logic        code_ready;
   logic [15:0] addr;
   logic [7:0]  cmd;
   logic        repeat_flag;

   modport master (output code_valid, addr, cmd, repeat_flag, input code_ready);
   modport slave  (input code_valid, addr, cmd, repeat_flag, output code_ready);
endinterface

// File: rtl/ir_pulse_timer.sv
// Synchronises the raw IR line, flags its edges and reports the width (in 10 us
// ticks) of the level that just ended; the running count saturates at all-ones.
module ir_pulse_timer
   import ir_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int WIDTH_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ir_i,
   output logic               rise_o,
   output logic               fall_o,
   output logic [WIDTH_W-1:0] width_o,
   output logic               sat_o
);

   localparam int DIV_RAW = CLK_HZ / TICK_HZ;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [2:0]         sync_q;
   logic [PRE_W-1:0]   pre_q;
   logic [WIDTH_W-1:0] cnt_q;
   logic [WIDTH_W-1:0] width_q;
   logic               rise_q;
   logic               fall_q;
   logic               tick;
   logic               edge_det;
   logic               sat;

   assign tick     = (pre_q == PRE_LAST);
   assign edge_det = sync_q[1] ^ sync_q[2];
   assign sat      = &cnt_q;

   // Idle line is high, so the synchroniser resets to 1 to avoid a false edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 3'b111;
         pre_q   <= '0;
         cnt_q   <= '0;
         width_q <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], ir_i};
         pre_q  <= tick ? '0 : pre_q + 1'b1;
         rise_q <= sync_q[1] & ~sync_q[2];
         fall_q <= ~sync_q[1] & sync_q[2];
         if (edge_det) begin
            width_q <= cnt_q;
            cnt_q   <= '0;
         end else if (tick && !sat) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign width_o = width_q;
   assign sat_o   = sat;

endmodule

// File: rtl/ir_nec_ctrl.sv
// NEC frame controller: leader/bit/repeat sequencing, integrity check and result
// handshake. Define IR_EXT_ADDR_EN to accept extended NEC (16-bit address).
module ir_nec_ctrl
   import ir_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TOL_PCT = 25,
   parameter int WIDTH_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ir_i,
   output logic          err_o,
   ir_nec_ctrl_if.master res
);

   localparam int LEAD_LO_MIN = tol_bound(T_LEAD_LO, TOL_PCT, 1'b0);
   localparam int LEAD_LO_MAX = tol_bound(T_LEAD_LO, TOL_PCT, 1'b1);
   localparam int LEAD_HI_MIN = tol_bound(T_LEAD_HI, TOL_PCT, 1'b0);
   localparam int LEAD_HI_MAX = tol_bound(T_LEAD_HI, TOL_PCT, 1'b1);
   localparam int REP_HI_MIN  = tol_bound(T_REP_HI, TOL_PCT, 1'b0);
   localparam int REP_HI_MAX  = tol_bound(T_REP_HI, TOL_PCT, 1'b1);
   localparam int BIT_LO_MIN  = tol_bound(T_BIT_LO, TOL_PCT, 1'b0);
   localparam int BIT_LO_MAX  = tol_bound(T_BIT_LO, TOL_PCT, 1'b1);
   localparam int ZERO_HI_MIN = tol_bound(T_ZERO_HI, TOL_PCT, 1'b0);
   localparam int ZERO_HI_MAX = tol_bound(T_ZERO_HI, TOL_PCT, 1'b1);
   localparam int ONE_HI_MIN  = tol_bound(T_ONE_HI, TOL_PCT, 1'b0);
   localparam int ONE_HI_MAX  = tol_bound(T_ONE_HI, TOL_PCT, 1'b1);

   logic               rise;
   logic               fall;
   logic               sat;
   logic [WIDTH_W-1:0] width;

   ir_pulse_timer #(
      .CLK_HZ  (CLK_HZ),
      .WIDTH_W (WIDTH_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .ir_i    (ir_i),
      .rise_o  (rise),
      .fall_o  (fall),
      .width_o (width),
      .sat_o   (sat)
   );

   function automatic logic in_win(input logic [WIDTH_W-1:0] w, input int lo, input int hi);
      return (int'(w) >= lo) && (int'(w) <= hi);
   endfunction

   logic m_lead_lo, m_lead_hi, m_rep_hi, m_bit_lo, m_zero_hi, m_one_hi;

   assign m_lead_lo = in_win(width, LEAD_LO_MIN, LEAD_LO_MAX);
   assign m_lead_hi = in_win(width, LEAD_HI_MIN, LEAD_HI_MAX);
   assign m_rep_hi  = in_win(width, REP_HI_MIN, REP_HI_MAX);
   assign m_bit_lo  = in_win(width, BIT_LO_MIN, BIT_LO_MAX);
   assign m_zero_hi = in_win(width, ZERO_HI_MIN, ZERO_HI_MAX);
   assign m_one_hi  = in_win(width, ONE_HI_MIN, ONE_HI_MAX);

   ir_state_e   state_q;
   logic [31:0] shift_q;
   logic [4:0]  bitcnt_q;
   logic [15:0] last_addr_q;
   logic [7:0]  last_cmd_q;
   logic        last_vld_q;
   logic        vld_q;
   ir_frame_t   res_q;
   logic        err_q;

   logic        timeout;
   logic        frame_ok;
   ir_frame_t   chk_frame;
   logic        pub_req;
   ir_frame_t   pub_frame;

   assign timeout = sat && (state_q != IDLE);

   // Received word is LSB first: byte0 sits in shift_q[7:0]
   always_comb begin
      chk_frame.cmd = shift_q[23:16];
      chk_frame.rpt = 1'b0;
`ifdef IR_EXT_ADDR_EN
      chk_frame.addr = shift_q[15:0];
      frame_ok       = (shift_q[31:24] == ~shift_q[23:16]);
`else
      chk_frame.addr = {8'h00, shift_q[7:0]};
      frame_ok       = (shift_q[31:24] == ~shift_q[23:16]) &&
                       (shift_q[15:8] == ~shift_q[7:0]);
`endif
   end

   always_comb begin
      pub_req   = 1'b0;
      pub_frame = chk_frame;
      if (!timeout) begin
         if (state_q == CHECK && frame_ok) begin
            pub_req = 1'b1;
         end else if (state_q == REP_LO && rise && m_bit_lo && last_vld_q) begin
            pub_req        = 1'b1;
            pub_frame.addr = last_addr_q;
            pub_frame.cmd  = last_cmd_q;
            pub_frame.rpt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bitcnt_q    <= '0;
         last_addr_q <= '0;
         last_cmd_q  <= '0;
         last_vld_q  <= 1'b0;
         vld_q       <= 1'b0;
         res_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
         end else begin
            case (state_q)
               IDLE: if (fall) state_q <= LEAD_LO;
               LEAD_LO: if (rise) begin
                  if (m_lead_lo) state_q <= LEAD_HI;
                  else begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
               LEAD_HI: if (fall) begin
                  if (m_lead_hi) begin
                     state_q  <= BIT_LO;
                     bitcnt_q <= '0;
                  end else if (m_rep_hi) begin
                     state_q <= REP_LO;
                  end else begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
               BIT_LO: if (rise) begin
                  if (m_bit_lo) state_q <= BIT_HI;
                  else begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
               BIT_HI: if (fall) begin
                  if (m_zero_hi || m_one_hi) begin
                     shift_q <= {m_one_hi, shift_q[31:1]};
                     if (bitcnt_q == 5'd31) state_q <= STOP;
                     else begin
                        bitcnt_q <= bitcnt_q + 5'd1;
                        state_q  <= BIT_LO;
                     end
                  end else begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
               STOP: if (rise) begin
                  if (m_bit_lo) state_q <= CHECK;
                  else begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
               REP_LO: if (rise) begin
                  state_q <= IDLE;
                  if (!m_bit_lo || !last_vld_q) err_q <= 1'b1;
               end
               CHECK: begin
                  state_q <= IDLE;
                  if (frame_ok) begin
                     last_addr_q <= chk_frame.addr;
                     last_cmd_q  <= chk_frame.cmd;
                     last_vld_q  <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end

         // A result still pending and not taken this cycle blocks the new one
         if (pub_req) begin
            if (!vld_q || res.code_ready) begin
               res_q <= pub_frame;
               vld_q <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end else if (vld_q && res.code_ready) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign res.code_valid  = vld_q;
   assign res.addr        = res_q.addr;
   assign res.cmd         = res_q.cmd;
   assign res.repeat_flag = res_q.rpt;
   assign err_o           = err_q;

endmodule

// File: tb/tb_ir_nec_ctrl.sv
// Directed bench for ir_nec_ctrl: table of IR frames plus hand sequences for
// handshake release, timeout and mid-frame reset. Runs with a 1-clock tick.
module tb_ir_nec_ctrl;

   localparam int GAP = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ir  = 1'b1;
   logic err;

   ir_nec_ctrl_if res();

   ir_nec_ctrl #(
      .CLK_HZ  (100_000),
      .TOL_PCT (25),
      .WIDTH_W (10)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ir_i  (ir),
      .err_o (err),
      .res   (res)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          err_cnt = 0;
   int          hs_cnt = 0;
   logic [15:0] cap_addr = '0;
   logic [7:0]  cap_cmd = '0;
   logic        cap_rpt = 1'b0;

   always @(negedge clk) begin
      if (err === 1'b1) err_cnt++;
      if (res.code_valid === 1'b1 && res.code_ready === 1'b1) begin
         hs_cnt++;
         cap_addr = res.addr;
         cap_cmd  = res.cmd;
         cap_rpt  = res.repeat_flag;
      end
   end

   typedef struct {
      int          kind;   // 0 full frame, 1 repeat frame, 2 leader only
      logic [7:0]  b0, b1, b2, b3;
      int          lead;
      logic        rdy;
      int          exp_hs;
      int          exp_err;
      logic        exp_vld;
      logic [15:0] exp_addr;
      logic [7:0]  exp_cmd;
      logic        exp_rpt;
      string       name;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input int kind, input logic [7:0] b0, b1, b2, b3,
                               input int lead, input logic rdy, input int hs, input int e,
                               input logic vld, input logic [15:0] a, input logic [7:0] c,
                               input logic r, input string nm);
      vec_t v;
      v.kind = kind; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.lead = lead;
      v.rdy = rdy; v.exp_hs = hs; v.exp_err = e; v.exp_vld = vld;
      v.exp_addr = a; v.exp_cmd = c; v.exp_rpt = r; v.name = nm;
      return v;
   endfunction

   function automatic logic [15:0] exp_addr(input logic [7:0] b0, input logic [7:0] b1);
`ifdef IR_EXT_ADDR_EN
      return {b1, b0};
`else
      return {8'h00, b0};
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic level(input logic v, input int n);
      ir = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_full(input logic [31:0] word, input int lead);
      level(1'b0, lead);
      level(1'b1, 450);
      for (int i = 0; i < 32; i++) begin
         level(1'b0, 56);
         level(1'b1, word[i] ? 169 : 56);
      end
      level(1'b0, 56);
      level(1'b1, GAP);
   endtask

   task automatic send_repeat();
      level(1'b0, 900);
      level(1'b1, 225);
      level(1'b0, 56);
      level(1'b1, GAP);
   endtask

   initial begin
      int   e0;
      int   h0;
      vec_t v;
      logic [15:0] a_norm;
      a_norm = exp_addr(8'h04, 8'hFB);

      vecs[0] = mk(0, 8'h04, 8'hFB, 8'h1C, 8'hE3, 900, 1'b1, 1, 0, 1'b0, a_norm, 8'h1C, 1'b0, "frame_04_1c");
      vecs[1] = mk(0, 8'h04, 8'hFB, 8'h1C, 8'hE3, 900, 1'b1, 1, 0, 1'b0, a_norm, 8'h1C, 1'b0, "frame_again");
      vecs[2] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 900, 1'b1, 1, 0, 1'b0, a_norm, 8'h1C, 1'b1, "repeat");
      vecs[3] = mk(0, 8'h04, 8'hFB, 8'h1C, 8'hE2, 900, 1'b1, 0, 1, 1'b0, 16'h0, 8'h0, 1'b0, "bad_cmd_cpl");
`ifdef IR_EXT_ADDR_EN
      vecs[4] = mk(0, 8'h04, 8'h04, 8'h1C, 8'hE3, 900, 1'b1, 1, 0, 1'b0, 16'h0404, 8'h1C, 1'b0, "ext_addr");
`else
      vecs[4] = mk(0, 8'h04, 8'h04, 8'h1C, 8'hE3, 900, 1'b1, 0, 1, 1'b0, 16'h0, 8'h0, 1'b0, "bad_addr_cpl");
`endif
      vecs[5] = mk(2, 8'h00, 8'h00, 8'h00, 8'h00, 600, 1'b1, 0, 1, 1'b0, 16'h0, 8'h0, 1'b0, "short_leader");
      vecs[6] = mk(0, 8'h10, 8'hEF, 8'h45, 8'hBA, 900, 1'b1, 1, 0, 1'b0, exp_addr(8'h10, 8'hEF), 8'h45, 1'b0, "frame_10_45");
      vecs[7] = mk(0, 8'h04, 8'hFB, 8'h1C, 8'hE3, 900, 1'b0, 0, 0, 1'b1, a_norm, 8'h1C, 1'b0, "held_first");
      vecs[8] = mk(0, 8'h10, 8'hEF, 8'h45, 8'hBA, 900, 1'b0, 0, 1, 1'b1, a_norm, 8'h1C, 1'b0, "overrun");

      res.code_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_code_valid", {31'b0, res.code_valid}, 32'd0);
      chk("rst_addr", {16'b0, res.addr}, 32'd0);
      chk("rst_cmd", {24'b0, res.cmd}, 32'd0);
      chk("rst_repeat", {31'b0, res.repeat_flag}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      rst = 1'b0;
      level(1'b1, GAP);

      for (int i = 0; i < 9; i++) begin
         v = vecs[i];
         res.code_ready = v.rdy;
         e0 = err_cnt;
         h0 = hs_cnt;
         case (v.kind)
            0: send_full({v.b3, v.b2, v.b1, v.b0}, v.lead);
            1: send_repeat();
            default: begin
               level(1'b0, v.lead);
               level(1'b1, GAP);
            end
         endcase
         chk({v.name, "_handshakes"}, hs_cnt - h0, v.exp_hs);
         chk({v.name, "_errs"}, err_cnt - e0, v.exp_err);
         chk({v.name, "_code_valid"}, {31'b0, res.code_valid}, {31'b0, v.exp_vld});
         if (v.exp_hs > 0) begin
            chk({v.name, "_addr"}, {16'b0, cap_addr}, {16'b0, v.exp_addr});
            chk({v.name, "_cmd"}, {24'b0, cap_cmd}, {24'b0, v.exp_cmd});
            chk({v.name, "_repeat"}, {31'b0, cap_rpt}, {31'b0, v.exp_rpt});
         end
         if (v.exp_vld) begin
            chk({v.name, "_held_addr"}, {16'b0, res.addr}, {16'b0, v.exp_addr});
            chk({v.name, "_held_cmd"}, {24'b0, res.cmd}, {24'b0, v.exp_cmd});
            chk({v.name, "_held_repeat"}, {31'b0, res.repeat_flag}, {31'b0, v.exp_rpt});
         end
         $display("vector %0d %s: handshakes=%0d errs=%0d code_valid=%0b",
                  i, v.name, hs_cnt - h0, err_cnt - e0, res.code_valid);
      end

      // Release the held result: code_valid must drop one cycle after ready
      h0 = hs_cnt;
      @(posedge clk);
      #2 res.code_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_code_valid", {31'b0, res.code_valid}, 32'd0);
      chk("release_handshakes", hs_cnt - h0, 32'd1);
      chk("release_addr", {16'b0, cap_addr}, 32'h0004);
      chk("release_cmd", {24'b0, cap_cmd}, 32'h1C);
      @(negedge clk);
      $display("release: code_valid=%0b addr=%04h cmd=%02h", res.code_valid, cap_addr, cap_cmd);

      // Line stuck low mid-bit until the width counter saturates
      e0 = err_cnt;
      h0 = hs_cnt;
      level(1'b0, 900);
      level(1'b1, 450);
      level(1'b0, 56);
      level(1'b1, 56);
      level(1'b0, 2000);
      level(1'b1, GAP);
      chk("timeout_errs", err_cnt - e0, 32'd1);
      chk("timeout_handshakes", hs_cnt - h0, 32'd0);
      $display("timeout: errs=%0d", err_cnt - e0);

      // Repeat held pending, then reset mid-frame clears everything at once
      res.code_ready = 1'b0;
      e0 = err_cnt;
      send_repeat();
      chk("pend_repeat_valid", {31'b0, res.code_valid}, 32'd1);
      chk("pend_repeat_flag", {31'b0, res.repeat_flag}, 32'd1);
      chk("pend_repeat_errs", err_cnt - e0, 32'd0);
      level(1'b0, 900);
      level(1'b1, 450);
      level(1'b0, 30);
      rst = 1'b1;
      #1;
      chk("midrst_code_valid", {31'b0, res.code_valid}, 32'd0);
      chk("midrst_addr", {16'b0, res.addr}, 32'd0);
      chk("midrst_cmd", {24'b0, res.cmd}, 32'd0);
      chk("midrst_repeat", {31'b0, res.repeat_flag}, 32'd0);
      chk("midrst_err", {31'b0, err}, 32'd0);
      $display("mid-frame reset: code_valid=%0b addr=%04h", res.code_valid, res.addr);
      ir = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      res.code_ready = 1'b1;
      level(1'b1, GAP);
      e0 = err_cnt;
      h0 = hs_cnt;
      send_repeat();
      chk("orphan_repeat_errs", err_cnt - e0, 32'd1);
      chk("orphan_repeat_handshakes", hs_cnt - h0, 32'd0);
      $display("repeat after reset: errs=%0d handshakes=%0d", err_cnt - e0, hs_cnt - h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
